// File: rtl/nios_mul_pkg.sv
// Shared encodings and widths for the sequential 32x32 multiply unit.
package nios_mul_pkg;

    localparam int W_OP   = 32;
    localparam int W_HALF = 16;
    localparam int W_ACC  = 64;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXSS = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXUU = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISS0,
        ISS1,
        ISS2,
        ISS3,
        DRAIN,
        FIN
    } state_e;

endpackage

// File: rtl/nios_mul_core16.sv
// 16x16 unsigned multiplier with a single registered product stage,
// clock enable and asynchronous clear.
module nios_mul_core16 #(
    parameter string DEVICE_FAMILY = "CYCLONEV",
    parameter int    MUL_LAT       = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    if (MUL_LAT != 1 || DEVICE_FAMILY == "") begin : g_bad_cfg
        $error("nios_mul_core16: only MUL_LAT=1 with a named family is supported");
    end

    logic [31:0] p_q;
    logic [31:0] p_d;

    always_comb begin
        p_d = p_q;
        if (en) p_d = a * b;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) p_q <= '0;
        else          p_q <= p_d;
    end

    assign p = p_q;

endmodule

// File: rtl/nios_mul_seq.sv
// Sequential 32x32 multiplier: four 16x16 partial products through one core.
// Define NIOS_MUL_SHORTCUT_EN to skip the Ahi*Bhi issue for low-word MUL.
module nios_mul_seq
    import nios_mul_pkg::*;
#(
    parameter string DEVICE_FAMILY = "CYCLONEV",
    parameter int    MUL_LAT       = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [W_OP-1:0] E_src1,
    input  logic [W_OP-1:0] E_src2,
    input  logic            start,
    input  logic [1:0]      op,
    output logic            busy,
    output logic            done,
    output logic [W_OP-1:0] result
);

    state_e             state_q, state_d;
    logic [W_OP-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [W_ACC-1:0]   acc_q, acc_d;
    logic [W_OP-1:0]    result_q, result_d;
    logic               done_q, done_d;

    logic               core_en;
    logic [W_HALF-1:0]  core_a, core_b;
    logic [2*W_HALF-1:0] core_p;
    logic [W_ACC-1:0]   p_ext;
    logic [W_OP-1:0]    hi_corr;

    nios_mul_core16 #(
        .DEVICE_FAMILY (DEVICE_FAMILY),
        .MUL_LAT       (MUL_LAT)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (core_en),
        .a       (core_a),
        .b       (core_b),
        .p       (core_p)
    );

    assign p_ext = {{(W_ACC-2*W_HALF){1'b0}}, core_p};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        core_en  = 1'b0;
        core_a   = a_q[W_HALF-1:0];
        core_b   = b_q[W_HALF-1:0];

        // Unsigned high word minus the two's-complement weight of each signed operand
        hi_corr = acc_q[W_ACC-1:W_OP];
        if ((op_q == OP_MULXSS || op_q == OP_MULXSU) && a_q[W_OP-1]) hi_corr = hi_corr - b_q;
        if (op_q == OP_MULXSS && b_q[W_OP-1])                         hi_corr = hi_corr - a_q;

        case (state_q)
            IDLE: begin
                // The done cycle still counts as busy, so no accept while done is high
                if (start && !done_q) begin
                    a_d     = E_src1;
                    b_d     = E_src2;
                    op_d    = op;
                    acc_d   = '0;
                    state_d = ISS0;
                end
            end
            ISS0: begin
                core_en = 1'b1;
                state_d = ISS1;
            end
            ISS1: begin
                core_en = 1'b1;
                core_b  = b_q[W_OP-1:W_HALF];
                acc_d   = acc_q + p_ext;
                state_d = ISS2;
            end
            ISS2: begin
                core_en = 1'b1;
                core_a  = a_q[W_OP-1:W_HALF];
                acc_d   = acc_q + (p_ext << W_HALF);
`ifdef NIOS_MUL_SHORTCUT_EN
                state_d = (op_q == OP_MUL) ? DRAIN : ISS3;
`else
                state_d = ISS3;
`endif
            end
            ISS3: begin
                core_en = 1'b1;
                core_a  = a_q[W_OP-1:W_HALF];
                core_b  = b_q[W_OP-1:W_HALF];
                acc_d   = acc_q + (p_ext << W_HALF);
                state_d = DRAIN;
            end
            DRAIN: begin
`ifdef NIOS_MUL_SHORTCUT_EN
                // On the short path the product in flight is Ahi*Blo, not Ahi*Bhi
                acc_d = (op_q == OP_MUL) ? acc_q + (p_ext << W_HALF) : acc_q + (p_ext << W_OP);
`else
                acc_d = acc_q + (p_ext << W_OP);
`endif
                state_d = FIN;
            end
            FIN: begin
                result_d = (op_q == OP_MUL) ? acc_q[W_OP-1:0] : hi_corr;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE) || done_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_nios_mul_seq.sv
// Scoreboard bench for nios_mul_seq: stimulus pushes expected results,
// a done-driven monitor pops and checks result and accept-to-done latency.
module tb_nios_mul_seq;
    import nios_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] E_src1 = '0;
    logic [31:0] E_src2 = '0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic        busy, done;
    logic [31:0] result;

    nios_mul_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .E_src1  (E_src1),
        .E_src2  (E_src2),
        .start   (start),
        .op      (op),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int lat_of(input logic [1:0] o);
`ifdef NIOS_MUL_SHORTCUT_EN
        return (o == OP_MUL) ? 5 : 6;
`else
        return 6;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (reset_n && done) begin
            exp_t e;
            check("done_has_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Returns at the negedge right after the accept edge (DUT in ISS0)
    task automatic issue(input string name, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        exp_t e;
        wait_idle(name);
        E_src1 = a;
        E_src2 = b;
        op     = o;
        start  = 1'b1;
        e.res = r; e.acc_cyc = cyc + 1; e.lat = lat_of(o); e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        // Scramble inputs after accept; latched operands must be unaffected
        E_src1 = ~a;
        E_src2 = ~b;
        op     = ~o;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"mul_tp",     OP_MUL,    32'h00010003, 32'h00020005, 32'h000B000F};
        vecs[1] = '{"xuu_ones",   OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2] = '{"xuu_zero",   OP_MULXUU, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[3] = '{"xss_m1m1",   OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[4] = '{"xss_min2",   OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[5] = '{"xss_min1",   OP_MULXSS, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[6] = '{"xsu_neg",    OP_MULXSU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[7] = '{"xsu_pos",    OP_MULXSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};

        repeat (2) @(negedge clk);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_result", result,    32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);

        // start while busy must be ignored and busy held through done
        issue("mul35", OP_MUL, 32'd3, 32'd5, 32'h0000000F);
        @(negedge clk);
        E_src1 = 32'd7; E_src2 = 32'd7; op = OP_MUL; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            check("busy_hold", 32'(busy), 32'd1);
            if (done) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("after_done_busy", 32'(busy), 32'd0);
        check("after_done_done", 32'(done), 32'd0);
        repeat (8) @(negedge clk);
        check("no_queued_start", 32'(busy), 32'd0);
        issue("mul77", OP_MUL, 32'd7, 32'd7, 32'h00000031);
        wait_idle("mul77_end");

        // Reset during ISS2 aborts the operation without a done
        issue("abort", OP_MUL, 32'd3, 32'd5, 32'h0000000F);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_result", result,    32'd0);
        reset_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        issue("mul_2p32", OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000);
        wait_idle("final");
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
